// File: rtl/ibr_pipe_adder.sv
// ibr_pipe_adder: carry-pipelined WIDTH-bit add/subtract, SEG bits per stage, one result per cycle.
module ibr_pipe_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Enable,
    input  logic             ValidIn,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ValidOut
);
    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || SEG > WIDTH || WIDTH % SEG != 0) begin : g_bad_cfg
        $error("ibr_pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    // Stage k consumes the low SEG bits of its operand slice and skews the rest onward.
    // B is inverted on entry, so Mode only survives as the stage-0 carry-in.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SEG;
        logic [IW-1:0]        w_a, w_b;
        logic                 w_c, w_v;
        logic [SEG:0]         w_seg;
        logic [(k+1)*SEG-1:0] w_sn;
        logic [(k+1)*SEG-1:0] r_s;
        logic                 r_c, r_v;
        if (k == 0) begin : g_in
            assign w_a  = A;
            assign w_b  = Mode ? ~B : B;
            assign w_c  = Mode;
            assign w_v  = ValidIn;
            assign w_sn = w_seg[SEG-1:0];
        end else begin : g_link
            assign w_a  = g_stage[k-1].g_skew.r_a;
            assign w_b  = g_stage[k-1].g_skew.r_b;
            assign w_c  = g_stage[k-1].r_c;
            assign w_v  = g_stage[k-1].r_v;
            assign w_sn = {w_seg[SEG-1:0], g_stage[k-1].r_s};
        end
        assign w_seg = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + (SEG+1)'(w_c);
        always_ff @(posedge Clk or negedge RstN) begin
            if (!RstN) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (Enable) begin
                r_v <= w_v;
                if (w_v) begin
                    r_c <= w_seg[SEG];
                    r_s <= w_sn;
                end
            end
        end
        if (k < STAGES - 1) begin : g_skew
            logic [IW-SEG-1:0] r_a, r_b;
            always_ff @(posedge Clk or negedge RstN) begin
                if (!RstN) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (Enable && w_v) begin
                    r_a <= w_a[IW-1:SEG];
                    r_b <= w_b[IW-1:SEG];
                end
            end
        end
    end

    assign S        = g_stage[STAGES-1].r_s;
    assign Cout     = g_stage[STAGES-1].r_c;
    assign ValidOut = g_stage[STAGES-1].r_v;
endmodule

// File: doc/ibr_pipe_adder.md
IBR_PIPE_ADDER -- requirements
Module: ibr_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits.
REQ-002 SHALL have parameter SEG, default 16, bits added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RstN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Enable, input, 1, global advance; 0 freezes every register in the block.
REQ-006 SHALL have port ValidIn, input, 1, A/B/Mode carry a transaction this cycle.
REQ-007 SHALL have port Mode, input, 1, operation select: 0 = A+B, 1 = A-B.
REQ-008 SHALL have port A, input, WIDTH, first operand.
REQ-009 SHALL have port B, input, WIDTH, second operand.
REQ-010 SHALL have port S, output, WIDTH, registered result.
REQ-011 SHALL have port Cout, output, 1, registered carry out of bit WIDTH-1.
REQ-012 SHALL have port ValidOut, output, 1, S/Cout hold a new result this cycle.

Function
REQ-013 SHALL accept a transaction at a rising edge where Enable=1 and ValidIn=1; throughput one transaction per cycle, no backpressure.
REQ-014 SHALL split operands into STAGES segments of SEG bits; stage k (0 = LSB) adds segment k plus carry from stage k-1; stage 0 carry-in = Mode.
REQ-015 SHALL add ~B (bitwise inverse) when Mode=1, giving two's-complement A-B modulo 2^WIDTH.
REQ-016 SHALL skew-register the upper operand segments and Mode so that every segment of one result comes from the same accepted A, B, Mode, regardless of input changes after acceptance.
REQ-017 SHALL present the result exactly STAGES enabled cycles after acceptance: ValidOut=1 for one enabled cycle, S = (A + (Mode ? ~B : B) + Mode) mod 2^WIDTH, Cout = carry out of the top segment.
REQ-018 SHALL define Cout in Mode=1 as "no borrow": Cout=1 iff A >= B unsigned.
REQ-019 SHALL shift a per-stage valid bit each edge with Enable=1; ValidIn=0 inserts a bubble that reaches ValidOut as 0 after STAGES cycles.
REQ-020 SHALL load stage-k data and carry registers only when Enable=1 and the incoming stage valid bit is 1; S and Cout hold the last valid result while ValidOut=0.
REQ-021 SHALL, when Enable=0, hold all data, carry, skew and valid registers, including ValidOut; in-flight transactions resume unchanged when Enable returns to 1.
REQ-022 SHALL, for STAGES=1, reduce to one registered WIDTH-bit add with latency 1.
REQ-023 SHALL treat WIDTH not a multiple of SEG, or SEG > WIDTH, as illegal configuration; the design flags it at elaboration.
REQ-024 SHALL drop carry beyond bit WIDTH-1 except as reported on Cout; no saturation.

Reset
REQ-025 SHALL, on RstN=0, asynchronously clear S, Cout, ValidOut, all stage data, carry, skew and valid registers to 0, independent of Clk and Enable.
REQ-026 SHALL discard all in-flight transactions on reset; the first ValidOut after release belongs to the first transaction accepted after release.

Verification
REQ-027 SHALL cover wrap: defaults, Mode=0, A=FFFF_FFFF_FFFF_FFFF, B=1, single accept -> after 4 cycles ValidOut=1 for one cycle, S=0, Cout=1.
REQ-028 SHALL cover subtract: Mode=1, A=0, B=1 -> S=FFFF_FFFF_FFFF_FFFF, Cout=0; then A=5, B=3 -> S=2, Cout=1.
REQ-029 SHALL cover streaming: 8 back-to-back accepts A=i, B=0000_0000_0000_FFFF (i=0..7), inputs changing every cycle -> 8 consecutive ValidOut cycles, S = i+FFFF in order, carry into bits 31:16 correct.
REQ-030 SHALL cover stall: accept 2 transactions, Enable=0 for 5 cycles mid-flight, inputs toggled randomly -> outputs frozen, results correct and in order after Enable=1, total latency 4 enabled cycles.
REQ-031 SHALL cover bubbles: ValidIn pattern 1,0,1,1 -> ValidOut pattern 1,0,1,1 starting 4 cycles later; S unchanged during the 0 cycle.
REQ-032 SHALL cover reset mid-operation: RstN=0 between clock edges with 3 transactions in flight -> S, Cout, ValidOut 0 immediately; no stale ValidOut after release.
